// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and bubble counter
// Build option: define ID_EX_LOAD_USE_STALL_EN to enable load-use hazard detection and stall bubbles.
module id_ex_stage #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        id_alu_op,
   input  logic              id_branch,
   input  logic              id_mem_read,
   input  logic              id_mem_to_reg,
   input  logic              id_mem_write,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [3:0]        id_funct,
   input  logic              ex_flush,
   output logic [1:0]        ex_alu_op,
   output logic              ex_branch,
   output logic              ex_mem_read,
   output logic              ex_mem_to_reg,
   output logic              ex_mem_write,
   output logic              ex_alu_src,
   output logic              ex_reg_write,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [3:0]        ex_funct,
   output logic              stall,
   output logic [CNT_W-1:0]  bubble_count
);

   logic [1:0]        alu_op_q,     alu_op_d;
   logic              branch_q,     branch_d;
   logic              mem_read_q,   mem_read_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              mem_write_q,  mem_write_d;
   logic              alu_src_q,    alu_src_d;
   logic              reg_write_q,  reg_write_d;
   logic [DATA_W-1:0] pc_q,         pc_d;
   logic [DATA_W-1:0] rd1_q,        rd1_d;
   logic [DATA_W-1:0] rd2_q,        rd2_d;
   logic [DATA_W-1:0] imm_q,        imm_d;
   logic [4:0]        rs1_q,        rs1_d;
   logic [4:0]        rs2_q,        rs2_d;
   logic [4:0]        rd_q,         rd_d;
   logic [3:0]        funct_q,      funct_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;

   logic load_bubble;

`ifdef ID_EX_LOAD_USE_STALL_EN
   logic hz;

   // Load in EX whose destination feeds a source of the decode instruction; x0 is never a real dependency.
   assign hz    = mem_read_q & (rd_q != 5'd0) & ((rd_q == id_rs1) | (rd_q == id_rs2));
   // A taken branch kills the decode instruction anyway, so it never needs to stall.
   assign stall = hz & ~ex_flush;
`else
   assign stall = 1'b0;
`endif

   // Flush and stall both replace the EX contents with one bubble; a simultaneous pair is one bubble.
   assign load_bubble = ex_flush | stall;

   // Next-state of the pipeline register: bubble (all zero) or a straight copy of decode.
   always_comb begin
      alu_op_d     = '0;
      branch_d     = 1'b0;
      mem_read_d   = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      reg_write_d  = 1'b0;
      pc_d         = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      imm_d        = '0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
      funct_d      = '0;
      if (!load_bubble) begin
         alu_op_d     = id_alu_op;
         branch_d     = id_branch;
         mem_read_d   = id_mem_read;
         mem_to_reg_d = id_mem_to_reg;
         mem_write_d  = id_mem_write;
         alu_src_d    = id_alu_src;
         reg_write_d  = id_reg_write;
         pc_d         = id_pc;
         rd1_d        = id_rd1;
         rd2_d        = id_rd2;
         imm_d        = id_imm;
         rs1_d        = id_rs1;
         rs2_d        = id_rs2;
         rd_d         = id_rd;
         funct_d      = id_funct;
      end
   end

   // Bubble counter advances once per inserted bubble and sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (load_bubble && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Pipeline register and counter; reset overrides flush and stall on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_op_q     <= '0;
         branch_q     <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         pc_q         <= '0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         imm_q        <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         funct_q      <= '0;
         cnt_q        <= '0;
      end else begin
         alu_op_q     <= alu_op_d;
         branch_q     <= branch_d;
         mem_read_q   <= mem_read_d;
         mem_to_reg_q <= mem_to_reg_d;
         mem_write_q  <= mem_write_d;
         alu_src_q    <= alu_src_d;
         reg_write_q  <= reg_write_d;
         pc_q         <= pc_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         imm_q        <= imm_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         funct_q      <= funct_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ex_alu_op     = alu_op_q;
   assign ex_branch     = branch_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_to_reg = mem_to_reg_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_alu_src    = alu_src_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_pc         = pc_q;
   assign ex_rd1        = rd1_q;
   assign ex_rd2        = rd2_q;
   assign ex_imm        = imm_q;
   assign ex_rs1        = rs1_q;
   assign ex_rs2        = rs2_q;
   assign ex_rd         = rd_q;
   assign ex_funct      = funct_q;
   assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage
module tb_id_ex_stage;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    id_alu_op;
   logic          id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
   logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic [3:0]    id_funct;
   logic          ex_flush;

   logic [1:0]    ex_alu_op;
   logic          ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
   logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]    ex_rs1, ex_rs2, ex_rd;
   logic [3:0]    ex_funct;
   logic          stall;
   logic [15:0]   bubble_count;

   logic [1:0]    s_alu_op;
   logic          s_branch, s_mem_read, s_mem_to_reg, s_mem_write, s_alu_src, s_reg_write;
   logic [DW-1:0] s_pc, s_rd1, s_rd2, s_imm;
   logic [4:0]    s_rs1, s_rs2, s_rd;
   logic [3:0]    s_funct;
   logic          s_stall;
   logic [3:0]    s_count;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_alu_op(id_alu_op), .id_branch(id_branch), .id_mem_read(id_mem_read),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
      .ex_flush(ex_flush),
      .ex_alu_op(ex_alu_op), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
      .stall(stall), .bubble_count(bubble_count)
   );

   id_ex_stage #(.DATA_W(DW), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset),
      .id_alu_op(id_alu_op), .id_branch(id_branch), .id_mem_read(id_mem_read),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
      .ex_flush(ex_flush),
      .ex_alu_op(s_alu_op), .ex_branch(s_branch), .ex_mem_read(s_mem_read),
      .ex_mem_to_reg(s_mem_to_reg), .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src),
      .ex_reg_write(s_reg_write), .ex_pc(s_pc), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
      .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
      .stall(s_stall), .bubble_count(s_count)
   );

   // ctl = {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
   typedef struct {
      logic [1:0]    alu_op;
      logic [5:0]    ctl;
      logic [DW-1:0] pc, rd1, rd2, imm;
      logic [4:0]    rs1, rs2, rd;
      logic [3:0]    funct;
      logic          flush;
      logic          exp_stall;   // expected stall with hazard detection built in
   } vec_t;

   localparam logic [5:0] C_RTYPE = 6'b000001;
   localparam logic [5:0] C_LOAD  = 6'b011011;
   localparam logic [5:0] C_STORE = 6'b000110;

   vec_t vecs[18];
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt;
   logic exp_stall_now;
   logic bub;
   logic [282:0] exp_bus, act_bus;

   function automatic vec_t mk(input logic [1:0] op, input logic [5:0] ctl,
                               input logic [DW-1:0] pc, input logic [DW-1:0] rd1,
                               input logic [DW-1:0] rd2, input logic [DW-1:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [3:0] funct, input logic flush, input logic st);
      vec_t v;
      v.alu_op = op; v.ctl = ctl; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.funct = funct; v.flush = flush; v.exp_stall = st;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      id_alu_op = v.alu_op;
      {id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = v.ctl;
      id_pc = v.pc; id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm;
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_funct = v.funct;
      ex_flush = v.flush;
   endtask

   task automatic check(input string name, input logic [282:0] act, input logic [282:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [282:0] ex_bus();
      return {ex_alu_op, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
              ex_reg_write, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct};
   endfunction

   initial begin
      //          op     ctl      pc      rd1    rd2    imm    rs1 rs2 rd  fn  fl st
      vecs[0]  = mk(2'b10, C_RTYPE, 64'h100, 64'd7, 64'd9, 64'd0,  1, 2, 5, 4'h0, 0, 0); // passthrough
      vecs[1]  = mk(2'b00, C_LOAD,  64'h104, 64'h2000, 64'd0, 64'd16, 2, 0, 6, 4'h3, 0, 0); // ld x6
      vecs[2]  = mk(2'b10, C_RTYPE, 64'h108, 64'h11, 64'h22, 64'd0, 6, 1, 7, 4'h0, 0, 1); // add x7,x6,x1
      vecs[3]  = mk(2'b10, C_RTYPE, 64'h108, 64'h33, 64'h22, 64'd0, 6, 1, 7, 4'h0, 0, 0); // re-presented
      vecs[4]  = mk(2'b00, C_LOAD,  64'h10c, 64'h3000, 64'd0, 64'd8, 3, 0, 0, 4'h3, 0, 0); // ld x0
      vecs[5]  = mk(2'b10, C_RTYPE, 64'h110, 64'd0, 64'd0, 64'd0,  0, 0, 9, 4'h8, 0, 0); // use x0
      vecs[6]  = mk(2'b00, C_LOAD,  64'h114, 64'h4000, 64'd0, 64'd4, 4, 0, 6, 4'h3, 0, 0); // ld x6
      vecs[7]  = mk(2'b10, C_RTYPE, 64'h118, 64'h5, 64'h6, 64'd0,  8, 3, 10, 4'h0, 0, 0); // use x8
      vecs[8]  = mk(2'b00, C_LOAD,  64'h11c, 64'h4000, 64'd0, 64'd0, 4, 0, 6, 4'h3, 0, 0); // ld x6
      vecs[9]  = mk(2'b10, C_RTYPE, 64'h120, 64'h1, 64'h2, 64'd0,  1, 6, 7, 4'h0, 1, 0); // hazard + flush
      vecs[10] = mk(2'b10, C_RTYPE, 64'h200, 64'h1, 64'h2, 64'd0,  1, 6, 7, 4'h0, 0, 0); // branch target
      vecs[11] = mk(2'b00, C_LOAD,  64'h204, 64'h5000, 64'd0, 64'd0, 4, 0, 5, 4'h3, 0, 0); // ld x5
      vecs[12] = mk(2'b00, C_LOAD,  64'h208, 64'hAA, 64'd0, 64'd8,  5, 0, 6, 4'h3, 0, 1); // ld x6,(x5)
      vecs[13] = mk(2'b00, C_LOAD,  64'h208, 64'hBB, 64'd0, 64'd8,  5, 0, 6, 4'h3, 0, 0); // re-presented
      vecs[14] = mk(2'b10, C_RTYPE, 64'h20c, 64'hC, 64'hC, 64'd0,  6, 6, 7, 4'h0, 0, 1); // add x7,x6,x6
      vecs[15] = mk(2'b10, C_RTYPE, 64'h20c, 64'hC, 64'hC, 64'd0,  6, 6, 7, 4'h0, 0, 0); // re-presented
      vecs[16] = mk(2'b00, C_STORE, 64'h210, 64'h9, 64'h8, 64'd24, 2, 3, 0, 4'h3, 1, 0); // plain flush
      vecs[17] = mk(2'b00, 6'b0,    64'h214, 64'h0, 64'h0, 64'h77, 0, 0, 0, 4'h0, 0, 0); // default NOP

      // Reset with arbitrary decode contents, including a flush that must not count.
      apply(mk(2'b11, 6'b111111, 64'hDEAD, 64'hBEEF, 64'hCAFE, 64'hF00D, 6, 6, 6, 4'hF, 1, 0));
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check($sformatf("reset_ex[%0d]", i), ex_bus(), '0);
         check($sformatf("reset_stall[%0d]", i), {282'd0, stall}, '0);
         check($sformatf("reset_cnt[%0d]", i), {267'd0, bubble_count}, '0);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 0;

      for (int i = 0; i < 18; i++) begin
         apply(vecs[i]);
`ifdef ID_EX_LOAD_USE_STALL_EN
         exp_stall_now = vecs[i].exp_stall;
`else
         exp_stall_now = 1'b0;
`endif
         #1;
         check($sformatf("stall[%0d]", i), {282'd0, stall}, {282'd0, exp_stall_now});
         bub = vecs[i].flush | exp_stall_now;
         exp_bus = bub ? '0 : {vecs[i].alu_op, vecs[i].ctl, vecs[i].pc, vecs[i].rd1, vecs[i].rd2,
                               vecs[i].imm, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].funct};
         if (bub) exp_cnt++;
         @(posedge clk); #1;
         check($sformatf("ex[%0d]", i), ex_bus(), exp_bus);
         check($sformatf("cnt[%0d]", i), {267'd0, bubble_count}, 283'(exp_cnt));
         @(negedge clk);
      end

      // Reset arriving while a load-use stall is pending.
      apply(vecs[1]);
      @(posedge clk);
      @(negedge clk);
      apply(vecs[2]);
      reset = 1'b1;
      #1;
`ifdef ID_EX_LOAD_USE_STALL_EN
      check("midstall_pre", {282'd0, stall}, {282'd0, 1'b1});
`else
      check("midstall_pre", {282'd0, stall}, '0);
`endif
      @(posedge clk); #1;
      check("midstall_ex", ex_bus(), '0);
      check("midstall_stall", {282'd0, stall}, '0);
      check("midstall_cnt", {267'd0, bubble_count}, '0);

      // Saturation: 20 flushes on a 4-bit counter sticks at 15, 16-bit counter reaches 20.
      @(negedge clk);
      reset = 1'b0;
      apply(vecs[16]);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         check($sformatf("sat_small[%0d]", i), {279'd0, s_count}, 283'((i > 15) ? 15 : i));
      end
      check("sat_big", {267'd0, bubble_count}, 283'(20));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the pipelined RV core. Captures the decode-stage control bundle (ALUOp, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite) together with operands, immediate, PC, register indices and funct bits. Detects load-use hazards against the instruction currently in EX and inserts a single bubble while stalling the front end. Honours a branch flush from EX and counts inserted bubbles for performance debug.

## Interface
Parameters:
- DATA_W, 64, width of register operands, immediate and PC
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_alu_op  in  2  ALUOp from the control unit
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  control bits from the control unit
- id_pc, id_rd1, id_rd2, id_imm  in  DATA_W each  PC, register-file read data and immediate
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct  in  4  {funct7[5], funct3}
- ex_flush  in  1  branch taken in EX; kill the instruction in decode
- ex_alu_op, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  2/1  registered control bundle
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered datapath fields
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_funct  out  4  registered funct bits
- stall  out  1  combinational; holds PC and IF/ID when high
- bubble_count  out  CNT_W  bubbles inserted since reset

## Operation
- Hazard (combinational): `hz = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
- `stall = hz & ~ex_flush`.
- Per-edge priority:
  1. `reset`: every output register cleared to 0; `bubble_count` = 0.
  2. `ex_flush`: bubble loaded, meaning all seven control outputs = 0 and the datapath fields are don't-care but driven to 0.
  3. `stall`: bubble loaded (same as above).
  4. Otherwise: every `id_*` field is copied into its `ex_*` register.
- Each bubble loaded on a non-reset edge, whether from flush or stall, increments `bubble_count`.
  - The counter saturates at all-ones and does not wrap.
- A stalled instruction is re-presented by IF/ID on the next cycle. The bubble clears `ex_mem_read`, so `hz` drops and the instruction enters EX.
  - A load-use hazard therefore costs exactly one cycle.
- Back-to-back loads with dependency chains: each dependent consumer stalls exactly once.
- A load followed by an instruction whose `id_rs1`/`id_rs2` matches a different register: no stall.
- `ex_rd == 0` never causes a stall.
- `ex_flush` together with `hz`: the flush wins, `stall = 0`, one bubble is loaded and the counter advances by 1, not 2.
- Decode-stage opcodes that the control unit defaults (all controls 0) pass through as NOPs. They are not treated as bubbles for counting.

## Timing
- Latency: one cycle from `id_*` to `ex_*`.
- `stall` is purely combinational from `ex_*` registers, `id_rs1`/`id_rs2` and `ex_flush`. There is no path from `id_*` control bits to `stall`.
- Reset asserted mid-stall: the next edge clears all registers, so `ex_mem_read = 0` and `stall` falls in that same cycle after the edge.
- Reset has priority over flush and stall on the same edge.
- All output registers read 0 from the first edge with reset high until the first edge with reset low.

## Configuration
- `ID_EX_LOAD_USE_STALL_EN` defined: hazard detection, `stall` generation and stall bubbles behave as described above.
- Not defined:
  - `stall` is tied to 0 and `hz` logic is removed.
  - Decode contents always load unless `ex_flush` or `reset`.
  - `bubble_count` counts flush bubbles only.
  - Software scheduling must then avoid load-use pairs.

## Test plan
- Reset: hold `reset` for 2 cycles with arbitrary `id_*` values -> all `ex_*` = 0, `stall` = 0, `bubble_count` = 0.
- Passthrough: R-type decode (`id_alu_op` = 2'b10, `id_reg_write` = 1, `id_rd` = 5, `id_rd1` = 7, `id_rd2` = 9) -> identical values on `ex_*` one cycle later, `stall` = 0.
- Load-use: `ld x6` in EX followed by `add x7,x6,x1` in decode -> `stall` = 1 for exactly one cycle, EX holds a zero-control bubble, the add enters EX the next cycle, `bubble_count` = 1.
- x0 / non-matching: load to x0 followed by a use of x0, and load to x6 followed by a use of x8 -> `stall` = 0 in both cases, no bubble.
- Flush with hazard: load-use condition and `ex_flush` = 1 on the same cycle -> `stall` = 0, one bubble, `bubble_count` +1.
- Saturation and macro-off:
  - With CNT_W = 4, force 20 flushes -> `bubble_count` = 15.
  - With the macro undefined, repeat the load-use case -> `stall` = 0 and the add enters EX immediately.
